// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall bus layout,
// default exception entry and controller FSM encoding.
package pipeline_ctrl_pkg;

  localparam int STALL_BUS_WIDTH = 6;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } ctrl_state_e;

  // Mask with bits [msb:0] set, used to build the stall vector.
  function automatic logic [STALL_BUS_WIDTH-1:0] stall_upto(input int msb);
    logic [STALL_BUS_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < STALL_BUS_WIDTH; i++) begin
      if (i <= msb) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_arbiter.sv
// Priority encoder from stage stall requests to the per-stage stall vector.
// The deepest requesting stage wins and freezes itself and everything older.
module pipeline_ctrl_stall_arbiter
  import pipeline_ctrl_pkg::*;
(
  input  logic                       stall_req_if,
  input  logic                       stall_req_id,
  input  logic                       stall_req_ex,
  input  logic                       stall_req_mem,
  output logic [STALL_BUS_WIDTH-1:0] stall
);

  // Deepest stage first; WB is never stalled.
  always_comb begin
    stall = '0;
    if (stall_req_mem) begin
      stall = stall_upto(STALL_MEM);
    end else if (stall_req_ex) begin
      stall = stall_upto(STALL_EX);
    end else if (stall_req_id) begin
      stall = stall_upto(STALL_ID);
    end else if (stall_req_if) begin
      stall = stall_upto(STALL_IF);
    end
    stall[STALL_WB] = 1'b0;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: stall arbitration, exception/ERET flush,
// PC redirect handshake with fetch, and stall-cycle counter.
//
// state       | meaning
// ST_IDLE     | normal flow, a committed exception/ERET may be taken
// ST_REDIRECT | redirect_pc presented to fetch until fetch is free to load it
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = ADDR_WIDTH'(EXC_VECTOR_DEFAULT),
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall_req_if,
  input  logic                       stall_req_id,
  input  logic                       stall_req_ex,
  input  logic                       stall_req_mem,
  input  logic                       exc_valid,
  input  logic                       exc_is_eret,
  input  logic [ADDR_WIDTH-1:0]      cp0_epc,
  output logic [STALL_BUS_WIDTH-1:0] stall,
  output logic                       flush,
  output logic                       redirect_valid,
  output logic [ADDR_WIDTH-1:0]      redirect_pc,
  output logic [CNT_WIDTH-1:0]       stall_cycles
);

  ctrl_state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0]      redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0]       stall_cycles_q, stall_cycles_d;
  logic [STALL_BUS_WIDTH-1:0] arb_stall;
  logic                       exc_take;

  pipeline_ctrl_stall_arbiter u_stall_arbiter (
    .stall_req_if  (stall_req_if),
    .stall_req_id  (stall_req_id),
    .stall_req_ex  (stall_req_ex),
    .stall_req_mem (stall_req_mem),
    .stall         (arb_stall)
  );

  // A MEM data-bus stall defers the exception; MEM keeps exc_valid asserted.
  assign exc_take = (state_q == ST_IDLE) && exc_valid && !stall_req_mem;

  // Next state, redirect target capture; flush cycle squashes the stall vector.
  // Outputs are gated by rst so they read 0 throughout reset.
  always_comb begin
    state_d        = state_q;
    redirect_pc_d  = redirect_pc_q;
    stall          = '0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (exc_take) begin
          flush         = 1'b1;
          redirect_pc_d = exc_is_eret ? cp0_epc : EXC_VECTOR;
          state_d       = ST_REDIRECT;
        end else begin
          stall = arb_stall;
        end
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        stall          = arb_stall;
        if (!stall_req_if) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!rst) begin
      stall          = '0;
      flush          = 1'b0;
      redirect_valid = 1'b0;
    end
    stall_cycles_d = stall[STALL_PC] ? stall_cycles_q + CNT_WIDTH'(1) : stall_cycles_q;
  end

  // State, redirect target and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      redirect_pc_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      redirect_pc_q  <= redirect_pc_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign redirect_pc  = redirect_pc_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: inputs change on the falling edge,
// outputs are sampled 1 time unit later.
module tb_pipeline_ctrl;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk;
  logic        rst;
  logic        stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
  logic        exc_valid, exc_is_eret;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] stall_cycles;

  int checks;
  int failures;
  logic [31:0] exp_cnt;

  pipeline_ctrl #(
    .ADDR_WIDTH (32),
    .EXC_VECTOR (32'hBFC0_0380),
    .CNT_WIDTH  (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_req_if   (stall_req_if),
    .stall_req_id   (stall_req_id),
    .stall_req_ex   (stall_req_ex),
    .stall_req_mem  (stall_req_mem),
    .exc_valid      (exc_valid),
    .exc_is_eret    (exc_is_eret),
    .cp0_epc        (cp0_epc),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stall_req_if  = 1'b0;
    stall_req_id  = 1'b0;
    stall_req_ex  = 1'b0;
    stall_req_mem = 1'b0;
    exc_valid     = 1'b0;
    exc_is_eret   = 1'b0;
    cp0_epc       = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    stall_req_mem = 1'b1;
    exc_valid     = 1'b1;
    next_cycle();
    #1;
    checks++;
    if (stall !== 6'b000000) begin
      failures++; $display("FAIL rst_stall got=%b exp=%b", stall, 6'b000000);
    end
    checks++;
    if (flush !== 1'b0 || redirect_valid !== 1'b0) begin
      failures++; $display("FAIL rst_flush_rv got=%b%b exp=00", flush, redirect_valid);
    end
    clear_inputs();
    next_cycle();
    rst = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b0 || flush !== 1'b0 || redirect_valid !== 1'b0 ||
        redirect_pc !== 32'h0 || stall_cycles !== 32'h0) begin
      failures++;
      $display("FAIL reset_release got stall=%b flush=%b rv=%b pc=%h cnt=%0d exp all zero",
               stall, flush, redirect_valid, redirect_pc, stall_cycles);
    end
    exp_cnt = 0;
  endtask

  task automatic test_stall_priority();
    logic [5:0] exp_tab [5];
    logic [3:0] req_tab [5];
    req_tab[0] = 4'b0001; exp_tab[0] = 6'b000011;
    req_tab[1] = 4'b0011; exp_tab[1] = 6'b000111;
    req_tab[2] = 4'b0111; exp_tab[2] = 6'b001111;
    req_tab[3] = 4'b1111; exp_tab[3] = 6'b011111;
    req_tab[4] = 4'b1000; exp_tab[4] = 6'b011111;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      {stall_req_mem, stall_req_ex, stall_req_id, stall_req_if} = req_tab[i];
      #1;
      checks++;
      if (stall !== exp_tab[i]) begin
        failures++; $display("FAIL prio_%0d got=%b exp=%b", i, stall, exp_tab[i]);
      end
    end
    exp_cnt = exp_cnt + 5;
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (stall_cycles !== exp_cnt) begin
      failures++; $display("FAIL prio_cnt got=%0d exp=%0d", stall_cycles, exp_cnt);
    end
  endtask

  task automatic test_ex_id_stall();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      stall_req_ex = 1'b1;
      stall_req_id = 1'b1;
      #1;
      checks++;
      if (stall !== 6'b001111) begin
        failures++; $display("FAIL ex_id_stall_%0d got=%b exp=%b", i, stall, 6'b001111);
      end
    end
    exp_cnt = exp_cnt + 3;
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (stall_cycles !== exp_cnt || stall !== 6'b0) begin
      failures++;
      $display("FAIL ex_id_cnt got cnt=%0d stall=%b exp cnt=%0d stall=000000",
               stall_cycles, stall, exp_cnt);
    end
  endtask

  task automatic test_exception();
    next_cycle();
    exc_valid = 1'b1;
    #1;
    checks++;
    if (flush !== 1'b1 || stall !== 6'b0 || redirect_valid !== 1'b0) begin
      failures++;
      $display("FAIL exc_flush got flush=%b stall=%b rv=%b exp 1 000000 0", flush, stall, redirect_valid);
    end
    next_cycle();
    exc_valid = 1'b0;
    #1;
    checks++;
    if (flush !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== VEC) begin
      failures++;
      $display("FAIL exc_redirect got flush=%b rv=%b pc=%h exp 0 1 %h", flush, redirect_valid, redirect_pc, VEC);
    end
    next_cycle();
    #1;
    checks++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0 || stall_cycles !== exp_cnt) begin
      failures++;
      $display("FAIL exc_idle got rv=%b flush=%b cnt=%0d exp 0 0 %0d", redirect_valid, flush, stall_cycles, exp_cnt);
    end
  endtask

  task automatic test_eret_if_hold();
    next_cycle();
    exc_valid    = 1'b1;
    exc_is_eret  = 1'b1;
    cp0_epc      = 32'h8000_0104;
    stall_req_if = 1'b1;
    #1;
    checks++;
    if (flush !== 1'b1 || stall !== 6'b0) begin
      failures++; $display("FAIL eret_flush got flush=%b stall=%b exp 1 000000", flush, stall);
    end
    next_cycle();
    exc_valid = 1'b0;
    cp0_epc   = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      #1;
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0104 || stall !== 6'b000011 || flush !== 1'b0) begin
        failures++;
        $display("FAIL eret_hold_%0d got rv=%b pc=%h stall=%b exp 1 80000104 000011", i, redirect_valid, redirect_pc, stall);
      end
    end
    exp_cnt = exp_cnt + 4;
    next_cycle();
    stall_req_if = 1'b0;
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0104) begin
      failures++; $display("FAIL eret_last got rv=%b pc=%h exp 1 80000104", redirect_valid, redirect_pc);
    end
    next_cycle();
    #1;
    checks++;
    if (redirect_valid !== 1'b0 || stall_cycles !== exp_cnt) begin
      failures++; $display("FAIL eret_done got rv=%b cnt=%0d exp 0 %0d", redirect_valid, stall_cycles, exp_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_mem_defer();
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      exc_valid     = 1'b1;
      stall_req_mem = 1'b1;
      #1;
      checks++;
      if (stall !== 6'b011111 || flush !== 1'b0) begin
        failures++; $display("FAIL mem_defer_%0d got stall=%b flush=%b exp 011111 0", i, stall, flush);
      end
    end
    exp_cnt = exp_cnt + 2;
    next_cycle();
    stall_req_mem = 1'b0;
    #1;
    checks++;
    if (flush !== 1'b1 || stall !== 6'b0) begin
      failures++; $display("FAIL mem_release got flush=%b stall=%b exp 1 000000", flush, stall);
    end
    next_cycle();
    exc_valid = 1'b0;
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== VEC || stall_cycles !== exp_cnt) begin
      failures++;
      $display("FAIL mem_redirect got rv=%b pc=%h cnt=%0d exp 1 %h %0d", redirect_valid, redirect_pc, stall_cycles, VEC, exp_cnt);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    next_cycle();
    exc_valid   = 1'b1;
    exc_is_eret = 1'b1;
    cp0_epc     = 32'h0000_0040;
    #1;
    checks++;
    if (flush !== 1'b1) begin
      failures++; $display("FAIL b2b_first got flush=%b exp 1", flush);
    end
    next_cycle();
    exc_is_eret = 1'b0;
    #1;
    checks++;
    if (flush !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0040) begin
      failures++;
      $display("FAIL b2b_ignored got flush=%b rv=%b pc=%h exp 0 1 00000040", flush, redirect_valid, redirect_pc);
    end
    next_cycle();
    #1;
    checks++;
    if (flush !== 1'b1 || redirect_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_second got flush=%b rv=%b exp 1 0", flush, redirect_valid);
    end
    next_cycle();
    exc_valid = 1'b0;
    #1;
    checks++;
    if (redirect_pc !== VEC || redirect_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_target got pc=%h rv=%b exp %h 1", redirect_pc, redirect_valid, VEC);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid_redirect();
    next_cycle();
    exc_valid    = 1'b1;
    exc_is_eret  = 1'b1;
    cp0_epc      = 32'hA5A5_0000;
    stall_req_if = 1'b1;
    next_cycle();
    exc_valid = 1'b0;
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'hA5A5_0000) begin
      failures++; $display("FAIL rmr_pre got rv=%b pc=%h exp 1 a5a50000", redirect_valid, redirect_pc);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || stall_cycles !== 32'h0 || stall !== 6'b0) begin
      failures++;
      $display("FAIL rmr_async got rv=%b pc=%h cnt=%0d stall=%b exp all zero", redirect_valid, redirect_pc, stall_cycles, stall);
    end
    next_cycle();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    exc_valid = 1'b1;
    #1;
    checks++;
    if (flush !== 1'b1 || redirect_valid !== 1'b0) begin
      failures++; $display("FAIL rmr_retake got flush=%b rv=%b exp 1 0", flush, redirect_valid);
    end
    next_cycle();
    exc_valid = 1'b0;
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== VEC) begin
      failures++; $display("FAIL rmr_redirect got rv=%b pc=%h exp 1 %h", redirect_valid, redirect_pc, VEC);
    end
    next_cycle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 0;
    test_reset();
    test_stall_priority();
    test_ex_id_stall();
    test_exception();
    test_eret_if_hold();
    test_mem_defer();
    test_back_to_back();
    test_reset_mid_redirect();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
